// File: rtl/cntr8_ctrl_if.sv
// rtl/cntr8_ctrl_if.sv - command/status and counter-control bundle for cntr8_ctrl
// slave: the controller side; master: the host plus the cntr8 instance it drives.
interface cntr8_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] start_val;
  logic [W-1:0] target_val;
  logic         abort;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [W-1:0] steps;
  logic         cnt_load;
  logic         cnt_inc;
  logic [W-1:0] cnt_d_in;
  logic [W-1:0] cnt_q;

  modport slave (
    input  start, start_val, target_val, abort, cnt_q,
    output busy, done, aborted, steps, cnt_load, cnt_inc, cnt_d_in
  );

  modport master (
    output start, start_val, target_val, abort, cnt_q,
    input  busy, done, aborted, steps, cnt_load, cnt_inc, cnt_d_in
  );
endinterface

// File: rtl/cntr8_ctrl.sv
// rtl/cntr8_ctrl.sv - load/step/park sequencer for one cntr8 counter
// Define CNTR8_CTRL_WRAP_EN to count along the shortest modular path.
module cntr8_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  cntr8_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_q,   state_d;
  logic [W-1:0] park_q,    park_d;
  logic [W-1:0] start_q,   start_d;
  logic [W-1:0] target_q,  target_d;
  logic         dir_q,     dir_d;
  logic [W-1:0] steps_q,   steps_d;
  logic         aborted_q, aborted_d;
  logic         dir_cmd;

`ifdef CNTR8_CTRL_WRAP_EN
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};
  logic [W-1:0] fwd_dist;
  assign fwd_dist = bus.target_val - bus.start_val;
  // A distance of exactly half the ring goes up.
  assign dir_cmd  = (fwd_dist <= HALF);
`else
  assign dir_cmd  = (bus.target_val > bus.start_val);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      park_q    <= '0;
      start_q   <= '0;
      target_q  <= '0;
      dir_q     <= 1'b0;
      steps_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      park_q    <= park_d;
      start_q   <= start_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      steps_q   <= steps_d;
      aborted_q <= aborted_d;
    end
  end

  // The counter steps on every cycle load is low, so every state except a
  // stepping RUN cycle reloads it to hold its value.
  always_comb begin
    state_d      = state_q;
    park_d       = park_q;
    start_d      = start_q;
    target_d     = target_q;
    dir_d        = dir_q;
    steps_d      = steps_q;
    aborted_d    = aborted_q;
    bus.cnt_load = 1'b1;
    bus.cnt_inc  = 1'b0;
    bus.cnt_d_in = park_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_d   = bus.start_val;
          target_d  = bus.target_val;
          dir_d     = dir_cmd;
          steps_d   = '0;
          aborted_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        bus.cnt_d_in = start_q;
        state_d      = RUN;
      end
      RUN: begin
        if (bus.cnt_q == target_q) begin
          bus.cnt_d_in = target_q;
          park_d       = target_q;
          state_d      = DONE;
        end else if (bus.abort) begin
          bus.cnt_d_in = bus.cnt_q;
          park_d       = bus.cnt_q;
          aborted_d    = 1'b1;
          state_d      = DONE;
        end else begin
          bus.cnt_load = 1'b0;
          bus.cnt_inc  = dir_q;
          if (steps_q != {W{1'b1}}) begin
            steps_d = steps_q + W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q == LOAD) || (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.aborted = aborted_q;
  assign bus.steps   = steps_q;

endmodule

// File: tb/tb_cntr8_ctrl.sv
// tb/tb_cntr8_ctrl.sv - directed self-checking bench for cntr8_ctrl with a cntr8 model
module tb_cntr8_ctrl;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  cntr8_ctrl_if #(.W(8)) bus ();

  cntr8_ctrl #(.W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cntr8: load has priority, otherwise count up or down every cycle.
  always @(posedge clk) begin
    if (bus.cnt_load)     bus.cnt_q <= bus.cnt_d_in;
    else if (bus.cnt_inc) bus.cnt_q <= bus.cnt_q + 8'd1;
    else                  bus.cnt_q <= bus.cnt_q - 8'd1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] sv, input logic [7:0] tv);
    bus.start_val  = sv;
    bus.target_val = tv;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, input int limit, output int cyc);
    cyc = cyc0;
    while (bus.done !== 1'b1 && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_q(input logic [7:0] v, input int limit, input string tag);
    int n;
    n = 0;
    while (bus.cnt_q !== v && n < limit) begin
      step();
      n++;
    end
    chk(tag, bus.cnt_q, v);
  endtask

  int          cyc;
  int          ndone;
  logic [7:0]  exp_steps;
  logic        exp_dir;

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.start_val  = 8'h00;
    bus.target_val = 8'h00;
    bus.abort      = 1'b0;
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      chk("rst_load",  bus.cnt_load, 1'b1);
      chk("rst_d_in",  bus.cnt_d_in, 8'h00);
      chk("rst_cnt_q", bus.cnt_q,    8'h00);
      chk("rst_busy",  bus.busy,     1'b0);
      chk("rst_done",  bus.done,     1'b0);
      step();
    end
    chk("rst_steps",   bus.steps,   8'h00);
    chk("rst_aborted", bus.aborted, 1'b0);
    chk("rst_inc",     bus.cnt_inc, 1'b0);

    // Up count 0x10 -> 0x14: done in cycle 7 after the start edge.
    issue(8'h10, 8'h14);
    chk("up_load_busy", bus.busy,     1'b1);
    chk("up_load_ld",   bus.cnt_load, 1'b1);
    chk("up_load_din",  bus.cnt_d_in, 8'h10);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("up_cnt_q", bus.cnt_q, 8'h10 + k[7:0]);
      chk("up_nodone", bus.done, 1'b0);
      step();
    end
    chk("up_done",    bus.done,    1'b1);
    chk("up_steps",   bus.steps,   8'd4);
    chk("up_aborted", bus.aborted, 1'b0);
    chk("up_hold",    bus.cnt_q,   8'h14);
    chk("up_busy",    bus.busy,    1'b0);
    step();
    chk("up_done_pulse", bus.done,  1'b0);
    chk("up_steps_held", bus.steps, 8'd4);
    step();
    chk("up_park", bus.cnt_q, 8'h14);

    // 0xFA -> 0x02: long way down by default, short wrap with the macro.
`ifdef CNTR8_CTRL_WRAP_EN
    exp_steps = 8'd8;
    exp_dir   = 1'b1;
`else
    exp_steps = 8'd248;
    exp_dir   = 1'b0;
`endif
    issue(8'hFA, 8'h02);
    step();
    chk("dn_first_q", bus.cnt_q,   8'hFA);
    chk("dn_dir",     bus.cnt_inc, exp_dir);
    wait_done(2, 400, cyc);
    chk("dn_done",    bus.done,  1'b1);
    chk("dn_latency", cyc,       32'(exp_steps) + 32'd3);
    chk("dn_steps",   bus.steps, exp_steps);
    chk("dn_cnt_q",   bus.cnt_q, 8'h02);
    step();

    // Equal start and target.
    issue(8'h33, 8'h33);
    wait_done(1, 20, cyc);
    chk("eq_done",    bus.done,  1'b1);
    chk("eq_latency", cyc,       32'd3);
    chk("eq_steps",   bus.steps, 8'd0);
    chk("eq_cnt_q",   bus.cnt_q, 8'h33);
    step();

    // Start pulsed while busy is ignored.
    issue(8'h00, 8'h05);
    step();
    bus.start_val  = 8'h80;
    bus.target_val = 8'h90;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done === 1'b1) ndone++;
      step();
    end
    chk("ign_ndone", ndone,     32'd1);
    chk("ign_cnt_q", bus.cnt_q, 8'h05);
    chk("ign_steps", bus.steps, 8'd5);

    // Abort in the same cycle the target is reached completes normally.
    issue(8'h50, 8'h52);
    wait_q(8'h52, 20, "abhit_reach");
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abhit_done",    bus.done,    1'b1);
    chk("abhit_aborted", bus.aborted, 1'b0);
    chk("abhit_steps",   bus.steps,   8'd2);
    step();

    // Abort mid-run parks the counter where it is.
    issue(8'h00, 8'h40);
    wait_q(8'h07, 30, "ab_reach");
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_done",    bus.done,     1'b1);
    chk("ab_aborted", bus.aborted,  1'b1);
    chk("ab_steps",   bus.steps,    8'd7);
    chk("ab_din",     bus.cnt_d_in, 8'h07);
    step();
    chk("ab_idle_q",  bus.cnt_q,    8'h07);
    chk("ab_pulse",   bus.done,     1'b0);
    step();
    chk("ab_park_q",  bus.cnt_q,    8'h07);

    // Abort outside RUN has no effect.
    bus.abort = 1'b1;
    step();
    step();
    chk("abidle_busy", bus.busy,  1'b0);
    chk("abidle_done", bus.done,  1'b0);
    chk("abidle_q",    bus.cnt_q, 8'h07);
    bus.abort = 1'b0;

    // Reset mid-run.
    issue(8'h20, 8'h30);
    wait_q(8'h25, 30, "rr_reach");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_busy",  bus.busy,     1'b0);
    chk("rr_done",  bus.done,     1'b0);
    chk("rr_load",  bus.cnt_load, 1'b1);
    chk("rr_din",   bus.cnt_d_in, 8'h00);
    chk("rr_steps", bus.steps,    8'h00);
    step();
    chk("rr_cnt_q", bus.cnt_q,    8'h00);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done === 1'b1) ndone++;
      step();
    end
    chk("rr_nodone", ndone,     32'd0);
    chk("rr_hold_q", bus.cnt_q, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
